regress_sequencer: RTL and testbench
====================================

Name: regress_sequencer

Overview:
Control block between the serial front end and the gradient-descent datapath inside top. It deserialises the LSB-first serial stream S into 16-bit words and writes them into the sample memory row by row. It then sequences training: per epoch it clears the gradient accumulator, streams every row through the datapath, and triggers one weight update. It raises done_ when all epochs are complete.

Parameters:
ADDR_WIDTH, 12, row address width
MAX_FEATURES, 15, maximum feature count; column index width is 4
LENGTH, 16, bits per serial word
DEPTH, 1024, memory rows

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
S  in  1  serial data bit, LSB of each word first
s_valid  in  1  S is sampled on this edge
feat  in  4  number of features
epoch  in  8  number of epochs
data_points  in  ADDR_WIDTH  last row index; rows 0..data_points are used
learn_rate  in  4  learning-rate shift amount
wr_en  out  1  memory write strobe, one cycle
wr_addr  out  ADDR_WIDTH  row being written
wr_col  out  4  column being written
wr_data  out  LENGTH  assembled word
rd_en  out  1  one-cycle pulse; datapath fetches row rd_addr
rd_addr  out  ADDR_WIDTH  row to process
dp_ack  in  1  datapath finished accumulating the current row
grad_clr  out  1  one-cycle pulse that clears the gradient accumulator
upd_en  out  1  weight-update request, level signal
upd_ack  in  1  weight update completed
lr_shift  out  4  latched learn_rate
cur_epoch  out  8  epochs completed so far
done_  out  1  training complete

Behaviour:
- Reset (RST=0, asynchronous) sets:
  - state to IDLE;
  - all outputs, counters and the shift register to 0.
  - Reset mid-operation aborts everything. No memory write or update is issued after RST falls.
- IDLE (first edge after RST rises):
  - latches feat, epoch, data_points and learn_rate;
  - saturates data_points to DEPTH-1;
  - sets col=feat, row=0, bit_cnt=0;
  - moves to LOAD. Config inputs are ignored after this edge.
- LOAD:
  - On s_valid: sr <= {S, sr[LENGTH-1:1]} and bit_cnt++.
  - On the edge that samples bit 15, the next cycle drives wr_en=1 with wr_data={S, sr[15:1]}, wr_addr=row, wr_col=col.
  - Column order: feat down to 0. After col 0, col reloads feat and row increments.
  - s_valid=0 holds all LOAD state.
- Word (row=data_points, col=0) written:
  - go to EPOCH_START, or go to DONE if epoch==0.
- EPOCH_START:
  - grad_clr=1 for one cycle, row=0, then FETCH.
- FETCH:
  - rd_en=1 and rd_addr=row for one cycle, then WAIT.
- WAIT:
  - Waits for dp_ack. dp_ack is sampled only in WAIT; an ack in any other state is ignored.
  - On dp_ack with row<data_points: row++ and go to FETCH.
  - On dp_ack with row==data_points: go to UPDATE.
  - Minimum row period is 2 cycles; there is no timeout.
- UPDATE:
  - upd_en held at 1 until upd_ack is sampled high.
  - On that edge: upd_en=0 and cur_epoch++.
  - If cur_epoch+1==epoch, go to DONE; otherwise go to EPOCH_START.
- DONE:
  - done_=1 and held until reset; all strobes are 0.
- lr_shift: valid from IDLE exit, constant afterwards.
- Outputs: all registered; no combinational path from any input to any output.
- Counter widths:
  - row: ADDR_WIDTH;
  - bit_cnt: 4 bits, wraps 15→0;
  - cur_epoch: 8 bits, cannot overflow because it stops at epoch.
- Simultaneous events:
  - dp_ack and upd_ack are never both relevant in the same state.
  - The last serial bit and the state change occur on the same edge.

Decomposition:
- Package regress_pkg holds:
  - the state enum (IDLE, LOAD, EPOCH_START, FETCH, WAIT, UPDATE, DONE);
  - LENGTH and the column-width constant.
- One sub-module, serial_word_rx: shift register plus bit counter, producing word_valid/word.
- The FSM and address counters stay in regress_sequencer.

Test Plan:
- Reset then feat=1, data_points=1, epoch=1, with 4 words 0x1234, 0xABCD, 0x0001, 0x8000 sent LSB-first with s_valid=1 → wr_en pulses with (row, col, data) = (0,1,0x1234), (0,0,0xABCD), (1,1,0x0001), (1,0,0x8000); then grad_clr fires.
- After load, datapath acks each rd_en 3 cycles later and upd_ack comes 2 cycles after upd_en → rd_addr sequence 0,1; one upd_en; cur_epoch=1; done_=1 and stays 1.
- epoch=3, data_points=2 → 3 grad_clr pulses, 9 rd_en pulses (rows 0,1,2 each epoch), 3 updates; done_ only after the third upd_ack.
- epoch=0 → done_=1 right after the last word is written; no rd_en or upd_en ever.
- s_valid deasserted for 5 cycles in mid-word → word assembled correctly; no spurious wr_en.
- RST pulled low while in WAIT on row 1 → all outputs go 0 immediately; after release, the FSM restarts in LOAD and no upd_en was seen.

Source files
------------

// File: rtl/regress_pkg.sv
// regress_pkg: shared types and constants for the regression sequencer.
package regress_pkg;
   localparam int LENGTH = 16;
   localparam int MAX_FEATURES = 15;
   localparam int COL_W = $clog2(MAX_FEATURES + 1);
   typedef enum logic [2:0] {IDLE, LOAD, EPOCH_START, FETCH, WAIT, UPDATE, DONE} state_t;
endpackage

// File: rtl/serial_word_rx.sv
// serial_word_rx: LSB-first deserialiser; word_valid marks the edge sampling the last bit.
module serial_word_rx import regress_pkg::*; (
   input  logic              CLK,
   input  logic              RST,
   input  logic              clr,
   input  logic              en,
   input  logic              s,
   input  logic              s_valid,
   output logic              word_valid,
   output logic [LENGTH-1:0] word
);
   logic [LENGTH-1:0] sr;
   logic [3:0] bit_cnt;
   logic sample;
   assign sample = en & s_valid;
   assign word_valid = sample && bit_cnt == 4'd15;
   assign word = {s, sr[LENGTH-1:1]};
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sr <= '0;
         bit_cnt <= '0;
      end else if (clr) begin
         sr <= '0;
         bit_cnt <= '0;
      end else if (sample) begin
         sr <= word;
         bit_cnt <= bit_cnt + 4'd1;
      end
   end
endmodule

// File: rtl/regress_sequencer.sv
// regress_sequencer: loads serial samples into memory, then sequences gradient-descent epochs.
module regress_sequencer import regress_pkg::*; #(
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH = 1024
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  S,
   input  logic                  s_valid,
   input  logic [COL_W-1:0]      feat,
   input  logic [7:0]            epoch,
   input  logic [ADDR_WIDTH-1:0] data_points,
   input  logic [3:0]            learn_rate,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [COL_W-1:0]      wr_col,
   output logic [LENGTH-1:0]     wr_data,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  dp_ack,
   output logic                  grad_clr,
   output logic                  upd_en,
   input  logic                  upd_ack,
   output logic [3:0]            lr_shift,
   output logic [7:0]            cur_epoch,
   output logic                  done_
);
   localparam logic [ADDR_WIDTH-1:0] ROW_MAX = ADDR_WIDTH'(DEPTH - 1);
   state_t state, state_n;
   logic [ADDR_WIDTH-1:0] row, row_n, cfg_dp;
   logic [COL_W-1:0] col, col_n, cfg_feat;
   logic [7:0] cfg_ep, ep_n;
   logic word_valid;
   logic [LENGTH-1:0] word;
   logic last_row;

   serial_word_rx u_rx (
      .CLK(CLK), .RST(RST), .clr(state == IDLE), .en(state == LOAD),
      .s(S), .s_valid(s_valid), .word_valid(word_valid), .word(word)
   );

   assign last_row = row == cfg_dp;

   always_comb begin
      state_n = state;
      row_n = row;
      col_n = col;
      ep_n = cur_epoch;
      case (state)
         IDLE: begin
            state_n = LOAD;
            row_n = '0;
            col_n = feat;
         end
         LOAD: if (word_valid) begin
            col_n = col == '0 ? cfg_feat : col - COL_W'(1);
            row_n = col == '0 && !last_row ? row + 1'b1 : row;
            if (last_row && col == '0) state_n = cfg_ep == '0 ? DONE : EPOCH_START;
         end
         EPOCH_START: begin
            row_n = '0;
            state_n = FETCH;
         end
         FETCH: state_n = WAIT;
         WAIT: if (dp_ack) begin
            state_n = last_row ? UPDATE : FETCH;
            row_n = last_row ? row : row + 1'b1;
         end
         UPDATE: if (upd_ack) begin
            ep_n = cur_epoch + 8'd1;
            state_n = ep_n == cfg_ep ? DONE : EPOCH_START;
         end
         default: ;
      endcase
   end

   // Strobes are registered from the next state so each is high exactly while its state is active.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         row <= '0;
         col <= '0;
         cfg_dp <= '0;
         cfg_feat <= '0;
         cfg_ep <= '0;
         lr_shift <= '0;
         cur_epoch <= '0;
         wr_en <= 1'b0;
         wr_addr <= '0;
         wr_col <= '0;
         wr_data <= '0;
         rd_en <= 1'b0;
         rd_addr <= '0;
         grad_clr <= 1'b0;
         upd_en <= 1'b0;
         done_ <= 1'b0;
      end else begin
         state <= state_n;
         row <= row_n;
         col <= col_n;
         cur_epoch <= ep_n;
         if (state == IDLE) begin
            cfg_feat <= feat;
            cfg_ep <= epoch;
            cfg_dp <= data_points > ROW_MAX ? ROW_MAX : data_points;
            lr_shift <= learn_rate;
         end
         wr_en <= word_valid;
         if (word_valid) begin
            wr_addr <= row;
            wr_col <= col;
            wr_data <= word;
         end
         rd_en <= state_n == FETCH;
         if (state_n == FETCH) rd_addr <= row_n;
         grad_clr <= state_n == EPOCH_START;
         upd_en <= state_n == UPDATE;
         done_ <= state_n == DONE;
      end
   end
endmodule

// File: tb/tb_regress_sequencer.sv
// tb_regress_sequencer: directed checks of loading, epoch sequencing, gaps and mid-run reset.
module tb_regress_sequencer;
   logic CLK = 0, RST = 0, S = 0, s_valid = 0;
   logic [3:0] feat = 0, learn_rate = 0;
   logic [7:0] epoch = 0;
   logic [11:0] data_points = 0;
   logic wr_en, rd_en, grad_clr, upd_en, done_;
   logic [11:0] wr_addr, rd_addr;
   logic [3:0] wr_col, lr_shift;
   logic [15:0] wr_data;
   logic [7:0] cur_epoch;
   logic dp_ack = 0, upd_ack = 0;
   int errs = 0, checks = 0;
   int cd = 0, ucd = 0, n_clr = 0, n_upd = 0;
   logic upd_prev = 0;
   logic [31:0] wr_log[$];
   int rd_q[$];
   int wb, rb, cb, ub, k;

   regress_sequencer dut (
      .CLK(CLK), .RST(RST), .S(S), .s_valid(s_valid), .feat(feat), .epoch(epoch),
      .data_points(data_points), .learn_rate(learn_rate), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_col(wr_col), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .dp_ack(dp_ack),
      .grad_clr(grad_clr), .upd_en(upd_en), .upd_ack(upd_ack), .lr_shift(lr_shift),
      .cur_epoch(cur_epoch), .done_(done_)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (wr_en) wr_log.push_back({wr_addr, wr_col, wr_data});
      if (rd_en) rd_q.push_back(int'(rd_addr));
      if (grad_clr) n_clr++;
      if (upd_en && !upd_prev) n_upd++;
      upd_prev = upd_en;
   end

   // Datapath model: ack 3 cycles after rd_en, update ack 2 cycles after upd_en.
   always @(negedge CLK) begin
      dp_ack = 0;
      upd_ack = 0;
      if (!RST) begin
         cd = 0;
         ucd = 0;
      end else begin
         if (rd_en) cd = 3;
         else if (cd > 0) begin
            cd--;
            dp_ack = cd == 0;
         end
         if (ucd > 0) begin
            ucd--;
            upd_ack = ucd == 0;
         end else if (upd_en) ucd = 2;
      end
   end

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic restart(input logic [3:0] f, input logic [11:0] dp, input logic [7:0] ep, input logic [3:0] lr);
      RST = 0;
      s_valid = 0;
      feat = f;
      data_points = dp;
      epoch = ep;
      learn_rate = lr;
      tick();
      RST = 1;
      tick();
   endtask

   task automatic send_word(input logic [15:0] w, input int gap_after, input int gap_len);
      for (int i = 0; i < 16; i++) begin
         S = w[i];
         s_valid = 1;
         tick();
         if (i == gap_after) begin
            s_valid = 0;
            repeat (gap_len) tick();
         end
      end
      s_valid = 0;
   endtask

   task automatic wait_done();
      k = 0;
      while (!done_ && k < 3000) begin
         tick();
         k++;
         if (upd_ack) chk("done_before_upd_ack", {31'd0, done_}, 0);
      end
      chk("done_reached", {31'd0, done_}, 1);
   endtask

   initial begin
      tick();
      chk("reset_outputs", {wr_en, rd_en, grad_clr, upd_en, done_, wr_addr, rd_addr}, 0);
      chk("reset_epoch_lr", {wr_data, cur_epoch, lr_shift}, 0);

      // Basic load of 2 rows x 2 columns, single epoch
      restart(4'd1, 12'd1, 8'd1, 4'd5);
      chk("lr_shift_latched", 32'(lr_shift), 5);
      wb = wr_log.size(); rb = rd_q.size(); cb = n_clr; ub = n_upd;
      send_word(16'h1234, -1, 0);
      send_word(16'hABCD, -1, 0);
      send_word(16'h0001, -1, 0);
      send_word(16'h8000, -1, 0);
      chk("last_wr_en", {31'd0, wr_en}, 1);
      chk("grad_clr_after_load", {31'd0, grad_clr}, 1);
      chk("wr_count", 32'(wr_log.size() - wb), 4);
      chk("wr0", wr_log[wb], {12'd0, 4'd1, 16'h1234});
      chk("wr1", wr_log[wb + 1], {12'd0, 4'd0, 16'hABCD});
      chk("wr2", wr_log[wb + 2], {12'd1, 4'd1, 16'h0001});
      chk("wr3", wr_log[wb + 3], {12'd1, 4'd0, 16'h8000});
      wait_done();
      chk("rd_count_e1", 32'(rd_q.size() - rb), 2);
      chk("rd_addr0", 32'(rd_q[rb]), 0);
      chk("rd_addr1", 32'(rd_q[rb + 1]), 1);
      chk("upd_count_e1", 32'(n_upd - ub), 1);
      chk("clr_count_e1", 32'(n_clr - cb), 1);
      chk("cur_epoch_e1", 32'(cur_epoch), 1);
      repeat (5) tick();
      chk("done_held", {31'd0, done_}, 1);
      chk("strobes_idle_done", {wr_en, rd_en, grad_clr, upd_en}, 0);

      // Three epochs over three single-column rows
      restart(4'd0, 12'd2, 8'd3, 4'd2);
      wb = wr_log.size(); rb = rd_q.size(); cb = n_clr; ub = n_upd;
      send_word(16'h1111, -1, 0);
      send_word(16'h2222, -1, 0);
      send_word(16'h3333, -1, 0);
      chk("wr_e3_last", wr_log[wb + 2], {12'd2, 4'd0, 16'h3333});
      wait_done();
      chk("clr_count_e3", 32'(n_clr - cb), 3);
      chk("upd_count_e3", 32'(n_upd - ub), 3);
      chk("rd_count_e3", 32'(rd_q.size() - rb), 9);
      for (int i = 0; i < 9; i++) chk("rd_seq_e3", 32'(rd_q[rb + i]), 32'(i % 3));
      chk("cur_epoch_e3", 32'(cur_epoch), 3);

      // Zero epochs: done right after the last write
      restart(4'd0, 12'd0, 8'd0, 4'd1);
      rb = rd_q.size(); cb = n_clr; ub = n_upd;
      send_word(16'hBEEF, -1, 0);
      chk("e0_wr_en", {31'd0, wr_en}, 1);
      chk("e0_wr_data", 32'(wr_data), 16'hBEEF);
      chk("e0_done", {31'd0, done_}, 1);
      repeat (20) tick();
      chk("e0_no_rd", 32'(rd_q.size() - rb), 0);
      chk("e0_no_upd", 32'(n_upd - ub), 0);
      chk("e0_no_clr", 32'(n_clr - cb), 0);

      // s_valid gap of 5 cycles inside a word
      restart(4'd0, 12'd0, 8'd0, 4'd0);
      wb = wr_log.size();
      send_word(16'h5A3C, 7, 5);
      chk("gap_wr_count", 32'(wr_log.size() - wb), 1);
      chk("gap_word", wr_log[wb], {12'd0, 4'd0, 16'h5A3C});

      // Reset while waiting on row 1
      restart(4'd0, 12'd2, 8'd1, 4'd7);
      ub = n_upd;
      send_word(16'h0101, -1, 0);
      send_word(16'h0202, -1, 0);
      send_word(16'h0303, -1, 0);
      k = 0;
      while (!(rd_en && rd_addr == 12'd1) && k < 200) begin
         tick();
         k++;
      end
      chk("row1_fetch_seen", {31'd0, rd_en && rd_addr == 12'd1}, 1);
      tick();
      RST = 0;
      #1;
      chk("rst_strobes", {wr_en, rd_en, grad_clr, upd_en, done_, rd_addr}, 0);
      chk("rst_regs", {wr_data, cur_epoch, lr_shift}, 0);
      chk("rst_no_upd", 32'(n_upd - ub), 0);
      tick();
      RST = 1;
      tick();
      wb = wr_log.size();
      send_word(16'h0F0F, -1, 0);
      chk("restart_wr", {31'd0, wr_en}, 1);
      chk("restart_word", wr_log[wb], {12'd0, 4'd0, 16'h0F0F});
      chk("restart_lr", 32'(lr_shift), 7);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
